// File: rtl/qed_encoder_if.sv
// Handshake bundle between the IFU-side driver and qed_encoder: original-instruction
// input stream, issued-instruction output stream, mode controls and FIFO occupancy.
interface qed_encoder_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          qed_enable;
  logic          qed_flush;
  logic [31:0]   in_instruction;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_instruction;
  logic          out_is_dup;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] dup_count;

  modport master (
    output qed_enable, qed_flush, in_instruction, in_valid, out_ready,
    input  in_ready, out_instruction, out_is_dup, out_valid, dup_count
  );

  modport slave (
    input  qed_enable, qed_flush, in_instruction, in_valid, out_ready,
    output in_ready, out_instruction, out_is_dup, out_valid, dup_count
  );
endinterface

// File: rtl/qed_encoder.sv
// QED transmit encoder: forwards originals, builds EDDI-V duplicates into a FIFO and
// issues them as a batch. Define QED_MEM_OFFSET_EN to add MEM_OFFSET to LW/SW duplicates.
module qed_encoder #(
  parameter int          DEPTH      = 4,
  parameter logic [11:0] MEM_OFFSET = 12'h400
) (
  input logic         CLK,
  input logic         RESET,
  qed_encoder_if.slave bus
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef QED_MEM_OFFSET_EN
  localparam logic [11:0] IMM_ADJ = MEM_OFFSET;
`else
  localparam logic [11:0] IMM_ADJ = 12'h000;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic {ORIG, DRAIN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [31:0]   fifo_mem [DEPTH];
  logic [31:0]   out_instr_q;
  logic          out_dup_q, out_valid_q;
  logic          free, in_ready, accept, push, pop;

  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : (r | 5'b10000);
  endfunction

  function automatic logic is_duplicable(input logic [31:0] i);
    case (i[6:0])
      OP_R, OP_I, OP_LUI, OP_AUIPC: return 1'b1;
      OP_LOAD, OP_STORE:            return i[14:12] == 3'b010;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [31:0] i);
    logic [31:0] e;
    logic [11:0] imm;
    e   = i;
    imm = 12'h000;
    case (i[6:0])
      OP_R: begin
        e[11:7]  = remap(i[11:7]);
        e[19:15] = remap(i[19:15]);
        e[24:20] = remap(i[24:20]);
      end
      OP_I: begin
        e[11:7]  = remap(i[11:7]);
        e[19:15] = remap(i[19:15]);
      end
      OP_LOAD: begin
        e[11:7]  = remap(i[11:7]);
        e[19:15] = remap(i[19:15]);
        imm      = i[31:20] + IMM_ADJ;
        e[31:20] = imm;
      end
      OP_STORE: begin
        // The store immediate is split across two fields; adjust it as one 12-bit value.
        e[19:15] = remap(i[19:15]);
        e[24:20] = remap(i[24:20]);
        imm      = {i[31:25], i[11:7]} + IMM_ADJ;
        e[31:25] = imm[11:5];
        e[11:7]  = imm[4:0];
      end
      OP_LUI, OP_AUIPC: e[11:7] = remap(i[11:7]);
      default: ;
    endcase
    return e;
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    if (RESET) state <= ORIG;
    else       state <= state_next;
  end

  // Output / handshake decode
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    free     = !out_valid_q || bus.out_ready;
    in_ready = 1'b0;
    pop      = 1'b0;
    unique case (state)
      ORIG:  in_ready = free && (count < FULL);
      DRAIN: pop      = free && (count != '0);
    endcase
    accept     = bus.in_valid && in_ready;
    push       = accept && bus.qed_enable && is_duplicable(bus.in_instruction);
    count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ORIG:  if (count_next == FULL || (bus.qed_flush && count_next != '0)) state_next = DRAIN;
      DRAIN: if (pop && count_next == '0)                                  state_next = ORIG;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; only entries below count are ever read.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= encode(bus.in_instruction);
  end

  // Output register: a load while the consumer takes the old word overwrites it directly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_instr_q <= 32'h0;
      out_dup_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_instr_q <= bus.in_instruction;
      out_dup_q   <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_instr_q <= fifo_mem[rd_ptr];
      out_dup_q   <= 1'b1;
      out_valid_q <= 1'b1;
    end else if (free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_instruction = out_instr_q;
  assign bus.out_is_dup      = out_dup_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.dup_count       = count;

endmodule

// File: doc/qed_encoder.md
# qed_encoder

Transmit-side counterpart of the QED field decoder. It takes fetched original instructions through a valid/ready handshake, forwards them, and builds their EDDI-V duplicates by remapping registers and, optionally, memory offsets. Duplicates are held in a FIFO and issued as a batch. It sits between the IFU and the QED decoder/issue path and produces the instruction stream the core executes in QED mode.

## Interface
- DEPTH, 4: duplicate FIFO depth; power of two, ≥2.
- MEM_OFFSET, 12'h400: offset added to LW/SW immediates of duplicates (used only with the macro below).
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- qed_enable  input  1  1 = duplicate; 0 = pure pass-through. Sampled only in ORIG.
- qed_flush  input  1  pulse: switch to draining buffered duplicates.
- in_instruction  input  32  original instruction.
- in_valid  input  1  in_instruction valid.
- in_ready  output  1  encoder accepts this cycle (combinational).
- out_instruction  output  32  issued instruction (registered).
- out_is_dup  output  1  out_instruction is a duplicate.
- out_valid  output  1  output register holds an instruction.
- out_ready  input  1  downstream consumes this cycle.
- dup_count  output  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Output register is free when `!out_valid || out_ready`. Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- States: ORIG, DRAIN. Reset state is ORIG.
- ORIG:
  - in_ready = free & (dup_count < DEPTH).
  - On accept, load in_instruction into the output register with out_is_dup=0.
  - If qed_enable=1 and the opcode is duplicable, push the encoded duplicate into the FIFO in the same cycle.
- Duplicable opcodes:
  - R (0110011), I (0010011), LW (0000011, funct3 010), SW (0100011, funct3 010), LUI (0110111), AUIPC (0010111).
  - J (1101111) and all other opcodes: forwarded, no duplicate.
- Encoding:
  - Every register field used by the format (rd, rs1, rs2) becomes r | 5'b10000.
  - x0 stays x0.
  - All other bits are unchanged.
- ORIG→DRAIN on the next edge when:
  - the FIFO is full after this cycle's push, or
  - qed_flush=1 and the FIFO is non-empty after this cycle's push.
  - qed_flush with an empty FIFO is ignored.
- DRAIN:
  - in_ready=0.
  - When the output register is free and the FIFO is non-empty, pop the head into the output register with out_is_dup=1.
  - DRAIN→ORIG on the edge where the last entry is popped.
  - qed_flush and qed_enable are ignored in DRAIN.
- Duplicates leave in FIFO order, identical to the order of the originals.
- If out_ready=1 and out_valid=0, nothing is emitted.
- If no load occurs while the output register is free, out_valid falls to 0.

## Timing
- Reset values:
  - out_valid=0, out_instruction=32'h0, out_is_dup=0.
  - FIFO empty, dup_count=0, state ORIG.
  - in_ready is therefore 1 after reset.
- Latency:
  - Accept to out_valid: 1 cycle.
  - Pop to out_valid: 1 cycle.
- Throughput: 1 instruction/cycle with out_ready held at 1.
- Load/emit overlap: a load and an emit in the same cycle overwrite the register; there is no bubble.
- Full boundary:
  - The cycle that pushes the DEPTH-th entry still accepts.
  - in_ready=0 from the next cycle.
- FIFO pointers wrap modulo DEPTH.
- RESET asserted mid-batch discards all FIFO contents and the output register, and returns to ORIG.
- out_instruction and out_is_dup must stay stable while out_valid=1 and out_ready=0.

## Configuration
- QED_MEM_OFFSET_EN defined:
  - LW duplicate immediate = imm12 + MEM_OFFSET.
  - SW duplicate immediate = {imm7,imm5} + MEM_OFFSET, re-split into imm7/imm5.
  - Arithmetic is 12-bit, wraps modulo 4096, no carry-out.
- QED_MEM_OFFSET_EN undefined: immediates are copied unchanged; only registers are remapped.

## Test plan
- ADD x3,x1,x2 (0x002081B3), then qed_flush, out_ready=1 → 0x002081B3 (dup=0) at cycle+1, then 0x012889B3 (dup=1). Returns to ORIG.
- LW x5,8(x2) (0x00812283) + flush:
  - with QED_MEM_OFFSET_EN → dup 0x40892A83;
  - without it → dup 0x00892A83.
- DEPTH=4, four back-to-back R-type inputs, no flush:
  - in_ready drops after the fourth accept;
  - four dups drain in order;
  - in_ready returns the cycle after the last pop.
- JAL x1,+16 (0x010000EF) then flush:
  - forwarded once;
  - flush ignored (FIFO empty);
  - state stays ORIG.
- out_ready held 0 for 3 cycles during DRAIN:
  - out_instruction/out_is_dup stable;
  - dup_count unchanged until out_ready=1.
- RESET asserted with 2 dups buffered → next cycle: out_valid=0, dup_count=0, in_ready=1; no stale dup is ever emitted.
